// File: rtl/ram_pkg.sv
// ram_pkg: shared types and default widths for the JK-flip-flop RAM bank
// controller (ram_ctrl). The request struct uses the default widths and is
// the natural type for request tables at the default configuration.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W  = 2;
  localparam int unsigned RAM_DATA_W  = 4;
  localparam int unsigned SETUP_CNT_W = 4;  // holds SETUP_CYC-1 for SETUP_CYC up to 15

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_VERIFY,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side controller for one JK-flip-flop RAM bank.
// Accepts one read/write request at a time over valid/ready, holds address
// and data stable for SETUP_CYC cycles before a single-cycle write strobe,
// adds one hold cycle, then presents the response until it is accepted.
// Optional feature: define RAM_CTRL_VERIFY_EN to read back every write and
// report a mismatch on rsp_err; without it rsp_err is tied to 0.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = RAM_ADDR_W,
  parameter int unsigned DATA_W    = RAM_DATA_W,
  parameter int unsigned SETUP_CYC = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("ram_ctrl: SETUP_CYC must be in 1..15");
  end

  localparam logic [SETUP_CNT_W-1:0] SETUP_LOAD = SETUP_CNT_W'(SETUP_CYC - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e                 state_q, state_d;
  logic [SETUP_CNT_W-1:0] cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   ram_sel_q, ram_sel_d;
  logic                   ram_write_q, ram_write_d;
`ifdef RAM_CTRL_VERIFY_EN
  logic                   rsp_err_q, rsp_err_d;
`endif

  // Next-state logic; every RAM-side and handshake output is derived from the
  // next state so that it is registered and glitch-free on the bank pins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_CTRL_VERIFY_EN
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d       = '{write: req_write, addr: req_addr, wdata: req_wdata};
          cnt_d       = SETUP_LOAD;
          rsp_rdata_d = '0;
`ifdef RAM_CTRL_VERIFY_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) state_d = ST_STROBE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_STROBE: begin
        // Reads sample the bank at the end of the strobe cycle; write acks carry 0.
        if (!req_q.write) rsp_rdata_d = ram_rdata;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
`ifdef RAM_CTRL_VERIFY_EN
        state_d = req_q.write ? ST_VERIFY : ST_RESP;
`else
        state_d = ST_RESP;
`endif
      end
      ST_VERIFY: begin
`ifdef RAM_CTRL_VERIFY_EN
        rsp_err_d = (ram_rdata != req_q.wdata);
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    ram_sel_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                  (state_d == ST_HOLD)  || (state_d == ST_VERIFY);
    ram_write_d = (state_d == ST_STROBE) && req_d.write;
  end

  // State, request and output registers; clear aborts any transaction.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ram_sel_q   <= 1'b0;
      ram_write_q <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values present before the edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      ram_sel_q   <= ram_sel_d;
      ram_write_q <= ram_write_d;
`ifdef RAM_CTRL_VERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Address and data come straight from the request register, which only
  // loads in IDLE, so they cannot move while ram_sel is high.
  assign ram_addr  = req_q.addr;
  assign ram_wdata = req_q.wdata;
  assign ram_sel   = ram_sel_q;
  assign ram_write = ram_write_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef RAM_CTRL_VERIFY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench for ram_ctrl with SETUP_CYC=3 and a
// behavioural 4x4 RAM bank (optional bit-0 stuck-at-0 fault). Define
// RAM_CTRL_VERIFY_EN for both bench and RTL to exercise the verify path.
module tb_ram_ctrl;
  import ram_pkg::*;

  localparam int S = 3;
`ifdef RAM_CTRL_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [1:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [3:0] rsp_rdata;
  logic       ram_sel, ram_write;
  logic [1:0] ram_addr;
  logic [3:0] ram_wdata, ram_rdata;

  ram_ctrl #(.ADDR_W(2), .DATA_W(4), .SETUP_CYC(S)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM bank model
  logic [3:0] mem [4];
  logic       stuck_en = 1'b0;
  int         write_pulses = 0;
  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_addr] <= stuck_en ? (ram_wdata & 4'b1110) : ram_wdata;
      write_pulses  <= write_pulses + 1;
    end
  end
  assign ram_rdata = ram_sel ? mem[ram_addr] : 4'h0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         first_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a request, wait for the handshake, push the expected response,
  // then return in cycle 1 with request inputs scrambled.
  task automatic issue(input ram_req_t r, input logic [3:0] exp_rdata, input logic exp_err);
    int   budget = 0;
    exp_t e;
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    while (!req_ready && budget < 200) begin
      step();
      budget++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata     = exp_rdata;
    e.err       = exp_err;
    e.first_cyc = cyc + S + 3 + ((VER != 0 && r.write) ? 1 : 0);
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
    req_write = ~r.write;
    req_addr  = ~r.addr;
    req_wdata = ~r.wdata;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_ram_sel"},   32'(ram_sel),   32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_write"}, 32'(ram_write), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  // Monitor: scoreboard compare on response handshake, latency of first
  // rsp_valid, response stability, and bank-side protocol rules.
  logic       seen = 1'b0;
  logic       prev_valid = 1'b0, prev_sel = 1'b0, prev_write = 1'b0;
  logic [3:0] prev_rdata = '0, prev_wdata = '0;
  logic [1:0] prev_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ram_write) begin
        check("write_without_sel", 32'(ram_sel), 32'd1);
        check("write_wider_than_1", 32'(prev_write), 32'd0);
      end
      if (prev_sel && ram_sel) begin
        check("addr_moved_under_sel", 32'(ram_addr), 32'(prev_addr));
        check("wdata_moved_under_sel", 32'(ram_wdata), 32'(prev_wdata));
      end
      if (prev_valid && rsp_valid)
        check("rsp_rdata_unstable", 32'(rsp_rdata), 32'(prev_rdata));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 32'(rsp_valid), 32'd0);
        end else begin
          if (!seen) begin
            check("rsp_latency", 32'(cyc), 32'(exp_q[0].first_cyc));
            seen = 1'b1;
          end
          if (rsp_ready) begin
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].rdata));
            check("rsp_err",   32'(rsp_err),   32'(exp_q[0].err));
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        seen = 1'b0;
      end
      prev_valid = rsp_valid & ~rsp_ready;
      prev_rdata = rsp_rdata;
      prev_sel   = ram_sel;
      prev_addr  = ram_addr;
      prev_wdata = ram_wdata;
      prev_write = ram_write;
    end
  end

  initial begin
    int pulses_before;
    int budget;

    // Reset state
    step();
    check_reset_outputs("por");
    clear = 1'b1;
    step();

    // Write 0xC to addr 2 with waveform check of setup/strobe/hold
    issue('{write: 1'b1, addr: 2'd2, wdata: 4'hC}, 4'h0, 1'b0);
    for (int n = 1; n <= S; n++) begin
      check("setup_sel",   32'(ram_sel),   32'd1);
      check("setup_write", 32'(ram_write), 32'd0);
      check("setup_addr",  32'(ram_addr),  32'd2);
      check("setup_wdata", 32'(ram_wdata), 32'hC);
      step();
    end
    check("strobe_write", 32'(ram_write), 32'd1);
    check("strobe_sel",   32'(ram_sel),   32'd1);
    step();
    check("hold_sel",   32'(ram_sel),   32'd1);
    check("hold_write", 32'(ram_write), 32'd0);
    step();
    if (VER != 0) begin
      check("verify_sel", 32'(ram_sel), 32'd1);
      step();
    end
    check("resp_sel",   32'(ram_sel),   32'd0);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Read addr 2 back
    issue('{write: 1'b0, addr: 2'd2, wdata: 4'h0}, 4'hC, 1'b0);
    drain();

    // Reset mid-SETUP of a write to addr 1
    pulses_before = write_pulses;
    issue('{write: 1'b1, addr: 2'd1, wdata: 4'hF}, 4'h0, 1'b0);
    step();
    clear = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    void'(exp_q.pop_back());
    step();
    check_reset_outputs("abort_edge");
    clear = 1'b1;
    step();
    check("abort_no_strobe", 32'(write_pulses), 32'(pulses_before));
    issue('{write: 1'b0, addr: 2'd1, wdata: 4'h0}, 4'h0, 1'b0);
    drain();

    // Backpressure on a read of addr 2
    rsp_ready = 1'b0;
    issue('{write: 1'b0, addr: 2'd2, wdata: 4'h0}, 4'hC, 1'b0);
    budget = 0;
    while (!rsp_valid && budget < 50) begin
      step();
      budget++;
    end
    check("bp_rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    for (int n = 0; n < 10; n++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'hC);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_ram_sel",   32'(ram_sel),   32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    drain();

    // Walking-one writes, reverse-order reads
    for (int i = 0; i < 4; i++)
      issue('{write: 1'b1, addr: 2'(i), wdata: 4'(1 << i)}, 4'h0, 1'b0);
    for (int i = 3; i >= 0; i--)
      issue('{write: 1'b0, addr: 2'(i), wdata: 4'h0}, 4'(1 << i), 1'b0);
    drain();

`ifdef RAM_CTRL_VERIFY_EN
    // Stuck-at-0 bit 0 on the bank: verify must flag only the write of 1
    stuck_en = 1'b1;
    issue('{write: 1'b1, addr: 2'd0, wdata: 4'b0001}, 4'h0, 1'b1);
    issue('{write: 1'b1, addr: 2'd0, wdata: 4'b0010}, 4'h0, 1'b0);
    drain();
    stuck_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Initiator-side controller for the team's small JK-flip-flop RAM banks: it accepts read/write requests over a valid/ready handshake and sequences address, data and write-strobe onto a single RAM bank with guaranteed setup and hold. It sits between the datapath and one RAM bank, returning read data and write acknowledgements on a response channel with backpressure.

## Interface
- ADDR_W, 2, RAM address width (bank depth 2^ADDR_W words)
- DATA_W, 4, RAM word width
- SETUP_CYC, 1, cycles address/data are held stable before the strobe; legal range 1..15
- clk  input  1  single clock, all state on rising edge
- clear  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  target word
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  DATA_W  read data; 0 for write acknowledgements
- rsp_err  output  1  write-verify mismatch (0 when RAM_CTRL_VERIFY_EN absent)
- ram_sel  output  1  bank select / address enable
- ram_addr  output  ADDR_W  RAM address
- ram_write  output  1  write strobe, one cycle wide
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data, combinational from ram_addr/ram_sel

## Operation
- States: IDLE, SETUP, STROBE, HOLD, (VERIFY), RESP.
- IDLE: req_ready=1. Handshake on req_valid&req_ready latches write/addr/wdata into request registers; go SETUP, setup counter loaded with SETUP_CYC-1.
- SETUP: ram_sel=1, ram_addr/ram_wdata driven from registers, ram_write=0. Counter decrements; at 0 go STROBE.
- STROBE: one cycle. Write: ram_write=1. Read: ram_write=0, ram_rdata captured into rsp_rdata at end of cycle. Go HOLD.
- HOLD: ram_sel, ram_addr, ram_wdata unchanged, ram_write=0. Go VERIFY if write and macro defined, else RESP.
- VERIFY: ram_write=0, ram_sel=1; capture ram_rdata, rsp_err = (ram_rdata != stored wdata). Go RESP.
- RESP: rsp_valid=1, ram_sel=0; stays until rsp_ready=1, then IDLE. rsp_rdata/rsp_err stable while rsp_valid=1.
- req_ready=1 only in IDLE; no request pipelining, one outstanding transaction.
- ram_write is never high outside STROBE; ram_addr/ram_wdata never change while ram_sel=1.
- Request inputs ignored outside IDLE; changes after handshake have no effect.

## Timing
- Reset (clear=0, any time, mid-transaction included): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_sel=0, ram_addr=0, ram_write=0, ram_wdata=0. An in-flight write may be aborted before or after its strobe; no response is produced.
- Handshake at edge 0 → SETUP cycles 1..SETUP_CYC → STROBE cycle SETUP_CYC+1 → HOLD +2 → rsp_valid from cycle SETUP_CYC+3 (read, or write without verify), SETUP_CYC+4 (write with verify).
- With rsp_ready held 1: back-to-back throughput one transaction per SETUP_CYC+4 (or +5) cycles; next req_ready the cycle after response handshake.
- rsp_ready held 0: RESP held indefinitely, RAM bank idle.

## Configuration
- RAM_CTRL_VERIFY_EN defined: every write adds VERIFY state, read-back comparison drives rsp_err for that response.
- Undefined: no VERIFY state, no comparator, rsp_err tied 0.

## Structure
- Shared package ram_pkg: state enum (IDLE, SETUP, STROBE, HOLD, VERIFY, RESP), default ADDR_W/DATA_W constants, request struct (write, addr, wdata).
- Single module; setup counter and verify comparator kept inline, no sub-module.

## Test plan
- Reset: clear=0 mid-SETUP of a write → all outputs at reset values next edge; ram_write never pulses; word unchanged on later read.
- Write 4'b1100 to addr 2, then read addr 2 → read response rsp_rdata=4'b1100 at cycle SETUP_CYC+3 after handshake; write ack rsp_rdata=0.
- SETUP_CYC=3: ram_addr stable with ram_sel=1 for 3 cycles before single-cycle ram_write, then one HOLD cycle.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata constant, req_ready=0, then release → IDLE next cycle.
- Write all four addresses 0..3 with 1,2,4,8, read back in reverse order → 8,4,2,1.
- RAM_CTRL_VERIFY_EN: RAM model with bit 0 stuck at 0, write 4'b0001 → rsp_err=1; write 4'b0010 → rsp_err=0.
